i2cmb_cmd_sequencer: RTL

//  Wishbone master that sequences a complete I2C transfer on the iicmb_m_wb core.
//  It accepts one request {rw, bus, addr, len}, then performs the CSR/DPR/CMDR write
//  and read cycles for the transfer. It streams write bytes in and read bytes out,
//  and reports a status code. Software and the bench issue whole transfers instead of

---
 rtl/i2cmb_cmd_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2cmb_cmd_sequencer.sv
// Runs one complete I2C transfer on the iicmb_m_wb core through its Wishbone port.
// Latency: one WB cycle per register access, plus the core's irq wait for each command.
// Backpressure: takes one request only in IDLE. Write bytes are taken one at a time. Read bytes stall until rdata_ready_i.
//
// Ports:
//   clk_i/rst_i       clock and synchronous active-high reset
//   req_*             transfer request {rw, bus, addr, len} with valid/ready
//   wdata_*           write byte stream (sink)
//   rdata_*           read byte stream (source)
//   done_o/status_o   end-of-request pulse with result code; busy_o is high outside IDLE
//   cyc_o..ack_i      Wishbone master toward the core (CSR=0, DPR=1, CMDR=2)
//   irq_i             core interrupt level, cleared by reading CMDR
module i2cmb_cmd_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int LEN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_rw_i,
  input  logic [WB_DATA_WIDTH-1:0]  req_bus_i,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]      req_len_i,
  input  logic [7:0]                wdata_i,
  input  logic                      wdata_valid_i,
  output logic                      wdata_ready_o,
  output logic [7:0]                rdata_o,
  output logic                      rdata_valid_o,
  input  logic                      rdata_ready_i,
  output logic                      done_o,
  output logic [2:0]                status_o,
  output logic                      busy_o,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

  localparam logic [2:0] C_WRITE   = 3'b001;
  localparam logic [2:0] C_RD_ACK  = 3'b010;
  localparam logic [2:0] C_RD_NAK  = 3'b011;
  localparam logic [2:0] C_START   = 3'b100;
  localparam logic [2:0] C_STOP    = 3'b101;
  localparam logic [2:0] C_SET_BUS = 3'b110;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_NAK     = 3'd1;
  localparam logic [2:0] ST_AL      = 3'd2;
  localparam logic [2:0] ST_ERR     = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;
  localparam logic [2:0] ST_BADLEN  = 3'd5;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_BUS, S_IRQ, S_WDATA, S_RDATA, S_DONE} state_t;
  // What the WB cycle in flight is for. This decides where to go on its ack.
  typedef enum logic [2:0] {B_CSR, B_DPR_WR, B_CMDR_WR, B_CMDR_RD, B_DPR_RD} step_t;
  typedef enum logic [2:0] {P_EN, P_BUS, P_START, P_ADDR, P_DATA, P_STOP} phase_t;

  state_t                    r_state, w_state;
  step_t                     r_step, w_step;
  phase_t                    r_phase, w_phase;
  logic [WB_ADDR_WIDTH-1:0]  r_adr, w_adr;
  logic [WB_DATA_WIDTH-1:0]  r_dat, w_dat;
  logic                      r_we, w_we;
  logic [2:0]                r_cmd, w_cmd;
  logic                      r_rw, w_rw;
  logic [WB_DATA_WIDTH-1:0]  r_bus, w_bus;
  logic [I2C_ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [LEN_WIDTH-1:0]      r_cnt, w_cnt;
  logic                      r_nak, w_nak;
  logic [TW-1:0]             r_tmo, w_tmo;
  logic [2:0]                r_status, w_status;
  logic [7:0]                r_rdata, w_rdata;

  // Command issue request. A command with a data byte starts with a DPR write.
  // Otherwise it goes straight to the CMDR write.
  logic                      w_issue;
  logic                      w_issue_has_d;
  logic [2:0]                w_issue_cmd;
  logic [WB_DATA_WIDTH-1:0]  w_issue_d;
  phase_t                    w_issue_phase;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_step   <= B_CSR;
      r_phase  <= P_EN;
      r_adr    <= '0;
      r_dat    <= '0;
      r_we     <= 1'b0;
      r_cmd    <= 3'd0;
      r_rw     <= 1'b0;
      r_bus    <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_nak    <= 1'b0;
      r_tmo    <= '0;
      r_status <= 3'd0;
      r_rdata  <= 8'd0;
    end else begin
      r_state  <= w_state;
      r_step   <= w_step;
      r_phase  <= w_phase;
      r_adr    <= w_adr;
      r_dat    <= w_dat;
      r_we     <= w_we;
      r_cmd    <= w_cmd;
      r_rw     <= w_rw;
      r_bus    <= w_bus;
      r_addr   <= w_addr;
      r_cnt    <= w_cnt;
      r_nak    <= w_nak;
      r_tmo    <= w_tmo;
      r_status <= w_status;
      r_rdata  <= w_rdata;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_step   = r_step;
    w_phase  = r_phase;
    w_adr    = r_adr;
    w_dat    = r_dat;
    w_we     = r_we;
    w_cmd    = r_cmd;
    w_rw     = r_rw;
    w_bus    = r_bus;
    w_addr   = r_addr;
    w_cnt    = r_cnt;
    w_nak    = r_nak;
    w_tmo    = r_tmo;
    w_status = r_status;
    w_rdata  = r_rdata;
    w_issue       = 1'b0;
    w_issue_has_d = 1'b0;
    w_issue_cmd   = 3'd0;
    w_issue_d     = '0;
    w_issue_phase = r_phase;

    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_rw   = req_rw_i;
          w_bus  = req_bus_i;
          w_addr = req_addr_i;
          w_cnt  = req_len_i;
          w_nak  = 1'b0;
          if (req_len_i == '0) begin
            w_status = ST_BADLEN;
            w_state  = S_DONE;
          end else begin
            w_phase = P_EN;
            w_step  = B_CSR;
            w_adr   = A_CSR;
            w_dat   = WB_DATA_WIDTH'(8'hC0);
            w_we    = 1'b1;
            w_state = S_BUS;
          end
        end
      end

      S_BUS: begin
        if (ack_i) begin
          case (r_step)
            B_CSR: begin
              w_issue       = 1'b1;
              w_issue_has_d = 1'b1;
              w_issue_cmd   = C_SET_BUS;
              w_issue_d     = r_bus;
              w_issue_phase = P_BUS;
            end
            B_DPR_WR: begin
              w_step = B_CMDR_WR;
              w_adr  = A_CMDR;
              w_dat  = WB_DATA_WIDTH'(r_cmd);
              w_we   = 1'b1;
            end
            B_CMDR_WR: begin
              // The wait counter counts cycles since this ack. The first wait cycle is 1.
              w_state = S_IRQ;
              w_tmo   = TW'(1);
            end
            B_DPR_RD: begin
              w_rdata = dat_i[7:0];
              w_state = S_RDATA;
            end
            default: begin
              // CMDR status read: AL wins over ERR, and ERR wins over NAK.
              if (dat_i[5]) begin
                w_status = ST_AL;
                w_state  = S_DONE;
              end else if (dat_i[4]) begin
                w_status = ST_ERR;
                w_state  = S_DONE;
              end else if (dat_i[6] && (r_phase == P_ADDR || r_phase == P_DATA)) begin
                w_nak         = 1'b1;
                w_issue       = 1'b1;
                w_issue_cmd   = C_STOP;
                w_issue_phase = P_STOP;
              end else begin
                case (r_phase)
                  P_BUS: begin
                    w_issue       = 1'b1;
                    w_issue_cmd   = C_START;
                    w_issue_phase = P_START;
                  end
                  P_START: begin
                    w_issue       = 1'b1;
                    w_issue_has_d = 1'b1;
                    w_issue_cmd   = C_WRITE;
                    w_issue_d     = WB_DATA_WIDTH'({r_addr, r_rw});
                    w_issue_phase = P_ADDR;
                  end
                  P_ADDR: begin
                    w_phase = P_DATA;
                    if (!r_rw) begin
                      w_state = S_WDATA;
                    end else begin
                      w_issue       = 1'b1;
                      w_issue_cmd   = (r_cnt == LEN_WIDTH'(1)) ? C_RD_NAK : C_RD_ACK;
                      w_issue_phase = P_DATA;
                    end
                  end
                  P_DATA: begin
                    if (!r_rw) begin
                      w_cnt = r_cnt - LEN_WIDTH'(1);
                      if (r_cnt == LEN_WIDTH'(1)) begin
                        w_issue       = 1'b1;
                        w_issue_cmd   = C_STOP;
                        w_issue_phase = P_STOP;
                      end else begin
                        w_state = S_WDATA;
                      end
                    end else begin
                      // The byte is in DPR. Fetch it before it is handed downstream.
                      w_step = B_DPR_RD;
                      w_adr  = A_DPR;
                      w_we   = 1'b0;
                    end
                  end
                  P_STOP: begin
                    w_status = r_nak ? ST_NAK : ST_OK;
                    w_state  = S_DONE;
                  end
                  default: begin
                    w_status = ST_ERR;
                    w_state  = S_DONE;
                  end
                endcase
              end
            end
          endcase
        end
      end

      S_IRQ: begin
        if (irq_i) begin
          w_step  = B_CMDR_RD;
          w_adr   = A_CMDR;
          w_we    = 1'b0;
          w_state = S_BUS;
        end else if (r_tmo >= TMO_LAST) begin
          w_status = ST_TIMEOUT;
          w_state  = S_DONE;
        end else begin
          w_tmo = r_tmo + TW'(1);
        end
      end

      S_WDATA: begin
        if (wdata_valid_i) begin
          w_issue       = 1'b1;
          w_issue_has_d = 1'b1;
          w_issue_cmd   = C_WRITE;
          w_issue_d     = WB_DATA_WIDTH'(wdata_i);
          w_issue_phase = P_DATA;
        end
      end

      S_RDATA: begin
        if (rdata_ready_i) begin
          w_cnt   = r_cnt - LEN_WIDTH'(1);
          w_issue = 1'b1;
          if (r_cnt == LEN_WIDTH'(1)) begin
            w_issue_cmd   = C_STOP;
            w_issue_phase = P_STOP;
          end else begin
            // When two bytes remain, the next read is the last one and it gets a NACK.
            w_issue_cmd   = (r_cnt == LEN_WIDTH'(2)) ? C_RD_NAK : C_RD_ACK;
            w_issue_phase = P_DATA;
          end
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_issue) begin
      w_phase = w_issue_phase;
      w_cmd   = w_issue_cmd;
      w_we    = 1'b1;
      w_state = S_BUS;
      if (w_issue_has_d) begin
        w_step = B_DPR_WR;
        w_adr  = A_DPR;
        w_dat  = w_issue_d;
      end else begin
        w_step = B_CMDR_WR;
        w_adr  = A_CMDR;
        w_dat  = WB_DATA_WIDTH'(w_issue_cmd);
      end
    end
  end

  assign req_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign cyc_o         = (r_state == S_BUS);
  assign stb_o         = (r_state == S_BUS);
  assign we_o          = r_we;
  assign adr_o         = r_adr;
  assign dat_o         = r_dat;
  assign wdata_ready_o = (r_state == S_WDATA) && wdata_valid_i;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = (r_state == S_RDATA);
  assign done_o        = (r_state == S_DONE);
  assign status_o      = (r_state == S_DONE) ? r_status : 3'd0;

endmodule
